// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the move scheduler and its history LIFO:
//   - game_status codes
//   - move direction codes
//   - scheduler FSM state encoding
//   - timeout limit (WAIT_ACK cycles) and history depth
//   - small helpers: opposite direction, "moves allowed" status test
// Optional feature macro used by the consumers of this package: MOVE_UNDO_EN.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        GS_CHOSE_BOARD  = 2'b00,
        GS_GAMING       = 2'b01,
        GS_GAME_INITIAL = 2'b10,
        GS_WINNED       = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_COMMIT   = 2'd3
    } sched_state_e;

    // Number of WAIT_ACK cycles without an ack before the move is abandoned.
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

    localparam int unsigned HIST_DEPTH = 16;
    localparam int unsigned HIST_AW    = $clog2(HIST_DEPTH);

    // Encoding places each direction next to its opposite, so flipping bit 0
    // swaps up<->down and left<->right.
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    function automatic logic moves_allowed(input logic [1:0] gs);
        return (gs == GS_GAMING) || (gs == GS_GAME_INITIAL);
    endfunction

endpackage

// File: rtl/move_history_lifo.sv
// -----------------------------------------------------------------------------
// move_history_lifo
// History of forward move directions for undo. HIST_DEPTH entries stored in a
// circular buffer: pushing when full overwrites the oldest entry.
// Only instantiated when MOVE_UNDO_EN is defined.
// Ports:
//   clk_d, rst   clock, asynchronous active-high reset (empties the LIFO)
//   i_clear      synchronous clear (empties the LIFO)
//   i_push       push i_data on top
//   i_pop        pop the top entry (ignored when empty)
//   i_data       direction to push
//   o_empty      no entries held
//   o_full       HIST_DEPTH entries held
//   o_top        most recently pushed entry (undefined when empty)
// -----------------------------------------------------------------------------
module move_history_lifo
    import game_pkg::*;
(
    input  logic       clk_d,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [1:0] i_data,
    output logic       o_empty,
    output logic       o_full,
    output logic [1:0] o_top
);

    localparam logic [HIST_AW:0] FULL_COUNT = (HIST_AW + 1)'(HIST_DEPTH);

    logic [1:0]         r_mem [HIST_DEPTH];
    logic [HIST_AW-1:0] r_top_ptr;
    logic [HIST_AW:0]   r_count;
    logic [HIST_AW-1:0] w_push_ptr;

    assign w_push_ptr = r_top_ptr + 1'b1;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == FULL_COUNT);
    assign o_top      = r_mem[r_top_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_top_ptr <= '0;
            r_count   <= '0;
        end else if (i_clear) begin
            r_top_ptr <= '0;
            r_count   <= '0;
        end else if (i_push) begin
            // Pointer wraps; when full the write lands on the oldest entry.
            r_top_ptr <= w_push_ptr;
            if (!o_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && !o_empty) begin
            r_top_ptr <= r_top_ptr - 1'b1;
            r_count   <= r_count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; r_count defines which entries
    // are valid, so clearing it empties the history without a wide reset.
    always_ff @(posedge clk_d) begin
        if (i_push && !i_clear) begin
            r_mem[w_push_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Turns debounced button levels into single move commands for the board
// datapath, with a valid/ack handshake, an ack timeout and optional undo.
// Optional feature: define MOVE_UNDO_EN to keep a move history and serve the
// undo button by issuing the opposite of the last board-changing move.
// Ports:
//   clk_d, rst            clock, asynchronous active-high reset
//   game_status[1:0]      game state code (see game_pkg)
//   btn_dir[3:0]          direction button levels: [0]up [1]down [2]left [3]right
//   btn_undo              undo button level
//   move_valid            move command valid (ISSUE and WAIT_ACK)
//   move_dir[1:0]         move direction, stable while move_valid
//   move_ack              board finished the move (1-cycle pulse)
//   move_changed          qualifies move_ack: board changed
//   active                pulse: forward move changed the board
//   undo_pulse            pulse: undo move completed
//   busy                  FSM not in IDLE
//   err_timeout           sticky: board never acknowledged a move
// -----------------------------------------------------------------------------
module move_scheduler
    import game_pkg::*;
(
    input  logic       clk_d,
    input  logic       rst,
    input  logic [1:0] game_status,
    input  logic [3:0] btn_dir,
    input  logic       btn_undo,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ack,
    input  logic       move_changed,
    output logic       active,
    output logic       undo_pulse,
    output logic       busy,
    output logic       err_timeout
);

    sched_state_e r_state;
    sched_state_e w_next_state;
    logic [3:0]   r_btn_dir_q;
    logic         r_btn_undo_q;
    dir_e         r_dir;
    logic         r_is_undo;
    logic         r_changed;
    logic [7:0]   r_wait_cnt;
    logic         r_err;

    logic [3:0]   w_dir_rise;
    logic         w_undo_rise;
    logic         w_status_ok;
    logic         w_hist_empty;
    logic [1:0]   w_hist_top;
    logic         w_sel_valid;
    logic         w_sel_undo;
    dir_e         w_sel_dir;
    logic         w_timeout;
    logic         w_commit_ok;
    logic [7:0]   w_wait_cnt_inc;

    assign w_dir_rise     = btn_dir & ~r_btn_dir_q;
    assign w_undo_rise    = btn_undo & ~r_btn_undo_q;
    assign w_status_ok    = moves_allowed(game_status);
    assign w_wait_cnt_inc = r_wait_cnt + 8'd1;

`ifdef MOVE_UNDO_EN
    move_history_lifo u_history (
        .clk_d   (clk_d),
        .rst     (rst),
        .i_clear (game_status == GS_CHOSE_BOARD),
        .i_push  (active),
        .i_pop   (w_commit_ok && r_is_undo),
        .i_data  (r_dir),
        .o_empty (w_hist_empty),
        .o_full  (),
        .o_top   (w_hist_top)
    );
    assign undo_pulse = w_commit_ok && r_is_undo;
`else
    // Undo never selectable: an always-empty history discards every undo edge.
    assign w_hist_empty = 1'b1;
    assign w_hist_top   = DIR_UP;
    assign undo_pulse   = 1'b0;
`endif

    // Fixed priority: up > down > left > right > undo.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_undo  = 1'b0;
        w_sel_dir   = DIR_UP;
        if (w_dir_rise[0]) begin
            w_sel_valid = 1'b1;
            w_sel_dir   = DIR_UP;
        end else if (w_dir_rise[1]) begin
            w_sel_valid = 1'b1;
            w_sel_dir   = DIR_DOWN;
        end else if (w_dir_rise[2]) begin
            w_sel_valid = 1'b1;
            w_sel_dir   = DIR_LEFT;
        end else if (w_dir_rise[3]) begin
            w_sel_valid = 1'b1;
            w_sel_dir   = DIR_RIGHT;
        end else if (w_undo_rise && !w_hist_empty) begin
            w_sel_valid = 1'b1;
            w_sel_undo  = 1'b1;
            w_sel_dir   = opposite_dir(dir_e'(w_hist_top));
        end
    end

    // Leaving the allowed statuses aborts any in-flight move on the next edge.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_status_ok && w_sel_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = w_status_ok ? ST_WAIT_ACK : ST_IDLE;
            end
            ST_WAIT_ACK: begin
                if (!w_status_ok) begin
                    w_next_state = ST_IDLE;
                end else if (move_ack) begin
                    w_next_state = ST_COMMIT;
                end else if (w_wait_cnt_inc == TIMEOUT_LIMIT) begin
                    w_next_state = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_btn_dir_q  <= '0;
            r_btn_undo_q <= 1'b0;
            r_dir        <= DIR_UP;
            r_is_undo    <= 1'b0;
            r_changed    <= 1'b0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_btn_dir_q  <= btn_dir;
            r_btn_undo_q <= btn_undo;

            if (r_state == ST_IDLE && w_status_ok && w_sel_valid) begin
                r_dir     <= w_sel_dir;
                r_is_undo <= w_sel_undo;
            end

            if (r_state == ST_WAIT_ACK && move_ack) begin
                r_changed <= move_changed;
            end

            r_wait_cnt <= (r_state == ST_WAIT_ACK) ? w_wait_cnt_inc : 8'd0;

            if (game_status == GS_CHOSE_BOARD) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pulses are suppressed if the game leaves the allowed statuses in COMMIT.
    assign w_commit_ok = (r_state == ST_COMMIT) && w_status_ok;
    assign active      = w_commit_ok && !r_is_undo && r_changed;
    assign move_valid  = (r_state == ST_ISSUE) || (r_state == ST_WAIT_ACK);
    assign move_dir    = r_dir;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
// Self-checking bench for move_scheduler. Directed scenarios plus randomized
// move transactions checked against a transaction-level model (priority pick,
// handshake length, pulse expectations, history kept as a queue).
// Works with or without MOVE_UNDO_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_move_scheduler;

    logic       clk_d = 1'b0;
    logic       rst;
    logic [1:0] game_status;
    logic [3:0] btn_dir;
    logic       btn_undo;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ack;
    logic       move_changed;
    logic       active;
    logic       undo_pulse;
    logic       busy;
    logic       err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MOVE_UNDO_EN
    localparam bit UNDO_EN = 1'b1;
`else
    localparam bit UNDO_EN = 1'b0;
`endif

    // Reference history: oldest at front, newest at back.
    logic [1:0] hist_q [$];

    always #5 clk_d = ~clk_d;

    move_scheduler dut (
        .clk_d        (clk_d),
        .rst          (rst),
        .game_status  (game_status),
        .btn_dir      (btn_dir),
        .btn_undo     (btn_undo),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .move_ack     (move_ack),
        .move_changed (move_changed),
        .active       (active),
        .undo_pulse   (undo_pulse),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] undo_of(input logic [1:0] d);
        case (d)
            2'd0:    return 2'd1;  // up   -> down
            2'd1:    return 2'd0;  // down -> up
            2'd2:    return 2'd3;  // left -> right
            default: return 2'd2;  // right -> left
        endcase
    endfunction

    // Which move (if any) a set of simultaneous edges should produce.
    function automatic void model_pick(input logic [3:0] dirs, input logic undo,
                                       output bit go, output logic [1:0] dir,
                                       output bit is_undo);
        go = 1'b0;
        dir = 2'd0;
        is_undo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dirs[i] && !go) begin
                go  = 1'b1;
                dir = i[1:0];
            end
        end
        if (!go && undo && UNDO_EN && hist_q.size() > 0) begin
            go      = 1'b1;
            is_undo = 1'b1;
            dir     = undo_of(hist_q[$]);
        end
    endfunction

    // Called at a negedge in IDLE with buttons released; returns at a negedge
    // in IDLE. lat = WAIT_ACK cycle on which ack is given; spur = also pulse
    // ack during ISSUE (must be ignored).
    task automatic do_move(input logic [3:0] dirs, input logic undo, input int lat,
                           input logic chg, input bit spur, output logic [1:0] obs_dir);
        bit         go;
        bit         is_undo;
        logic [1:0] edir;
        int         n_valid;
        bit         saw_pulse;
        bit         dir_moved;
        model_pick(dirs, undo, go, edir, is_undo);
        obs_dir   = 2'd0;
        n_valid   = 0;
        saw_pulse = 1'b0;
        dir_moved = 1'b0;
        btn_dir   = dirs;
        btn_undo  = undo;
        @(negedge clk_d);
        btn_dir  = 4'b0;
        btn_undo = 1'b0;
        if (!go) begin
            check("discard_busy", busy, 0);
            check("discard_valid", move_valid, 0);
            @(negedge clk_d);
            return;
        end
        while (move_valid === 1'b1 && n_valid < 64) begin
            n_valid++;
            if (n_valid == 1) obs_dir = move_dir;
            else if (move_dir !== obs_dir) dir_moved = 1'b1;
            saw_pulse    = saw_pulse | active | undo_pulse;
            move_ack     = (n_valid == lat + 1) || (spur && n_valid == 1);
            move_changed = (n_valid == lat + 1) ? chg : ~chg;
            @(negedge clk_d);
        end
        move_ack     = 1'b0;
        move_changed = 1'b0;
        check("valid_cycles", n_valid, lat + 1);
        check("move_dir", obs_dir, edir);
        check("dir_stable", dir_moved, 0);
        check("pulse_early", saw_pulse, 0);
        check("active", active, !is_undo && chg);
        check("undo_pulse", undo_pulse, is_undo);
        check("busy_commit", busy, 1);
        @(negedge clk_d);
        check("busy_idle", busy, 0);
        check("pulse_done", active | undo_pulse, 0);
        if (is_undo) begin
            void'(hist_q.pop_back());
        end else if (chg) begin
            hist_q.push_back(edir);
            if (hist_q.size() > 16) void'(hist_q.pop_front());
        end
    endtask

    task automatic do_timeout();
        int n_valid;
        bit saw_active;
        bit err_early;
        n_valid    = 0;
        saw_active = 1'b0;
        err_early  = 1'b0;
        btn_dir = 4'b0010;
        @(negedge clk_d);
        btn_dir = 4'b0;
        while (move_valid === 1'b1 && n_valid < 400) begin
            n_valid++;
            saw_active = saw_active | active;
            err_early  = err_early | err_timeout;
            @(negedge clk_d);
        end
        check("to_valid_cycles", n_valid, 256);
        check("to_err_early", err_early, 0);
        check("to_err", err_timeout, 1);
        check("to_busy", busy, 0);
        check("to_no_active", saw_active | active, 0);
    endtask

    task automatic clear_game();
        game_status = 2'b00;
        @(negedge clk_d);
        hist_q.delete();
        game_status = 2'b01;
        @(negedge clk_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] od;
        rst          = 1'b1;
        game_status  = 2'b01;
        btn_dir      = 4'b0;
        btn_undo     = 1'b0;
        move_ack     = 1'b0;
        move_changed = 1'b0;
        #1;
        check("rst_valid", move_valid, 0);
        check("rst_dir", move_dir, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active, 0);
        check("rst_undo", undo_pulse, 0);
        check("rst_err", err_timeout, 0);
        repeat (2) @(negedge clk_d);
        rst = 1'b0;
        @(negedge clk_d);

        // Up edge, ack on 3rd WAIT_ACK cycle: 4 valid cycles, one active pulse.
        do_move(4'b0001, 1'b0, 3, 1'b1, 1'b0, od);
        check("basic_up_dir", od, 0);

        // Left and right together: left wins, right is lost.
        do_move(4'b1100, 1'b0, 2, 1'b1, 1'b0, od);
        check("left_right_dir", od, 2);

        // Changed = 0: no active pulse (checked in task).
        do_move(4'b0010, 1'b0, 1, 1'b0, 1'b1, od);

        // Ack while idle is ignored.
        move_ack = 1'b1;
        move_changed = 1'b1;
        @(negedge clk_d);
        move_ack = 1'b0;
        check("idle_ack_busy", busy, 0);
        check("idle_ack_active", active, 0);

        // Edges while status is 00 or 11 are dropped, not queued.
        game_status = 2'b11;
        btn_dir = 4'b0001;
        @(negedge clk_d);
        btn_dir = 4'b0;
        check("winned_edge_busy", busy, 0);
        game_status = 2'b00;
        btn_dir = 4'b1000;
        @(negedge clk_d);
        btn_dir = 4'b0;
        hist_q.delete();
        game_status = 2'b01;
        @(negedge clk_d);
        check("chose_edge_busy", busy, 0);

        // Abort during WAIT_ACK, plus an edge while busy that must not queue.
        btn_dir = 4'b0100;
        @(negedge clk_d);
        btn_dir = 4'b1000;
        @(negedge clk_d);
        btn_dir = 4'b0;
        @(negedge clk_d);
        check("ab_valid_before", move_valid, 1);
        game_status = 2'b11;
        @(negedge clk_d);
        check("ab_valid", move_valid, 0);
        check("ab_busy", busy, 0);
        move_ack = 1'b1;
        move_changed = 1'b1;
        @(negedge clk_d);
        move_ack = 1'b0;
        check("ab_late_ack_active", active, 0);
        check("ab_late_ack_busy", busy, 0);
        game_status = 2'b01;
        repeat (2) @(negedge clk_d);
        check("ab_no_queued_move", busy, 0);

        // Timeout, then asynchronous reset mid-WAIT_ACK (also clears error).
        do_timeout();
        btn_dir = 4'b1000;
        @(negedge clk_d);
        btn_dir = 4'b0;
        @(negedge clk_d);
        check("rs_valid_pre", move_valid, 1);
        check("rs_err_pre", err_timeout, 1);
        #2 rst = 1'b1;
        #1;
        check("rs_valid", move_valid, 0);
        check("rs_dir", move_dir, 0);
        check("rs_busy", busy, 0);
        check("rs_active", active, 0);
        check("rs_undo", undo_pulse, 0);
        check("rs_err", err_timeout, 0);
        hist_q.delete();
        @(negedge clk_d);
        rst = 1'b0;
        @(negedge clk_d);

        // Second timeout, cleared by CHOSE_BOARD.
        do_timeout();
        game_status = 2'b00;
        @(negedge clk_d);
        check("to_err_clear", err_timeout, 0);
        hist_q.delete();
        game_status = 2'b01;
        @(negedge clk_d);

        // Undo: up, right, then three undos.
        clear_game();
        do_move(4'b0001, 1'b0, 1, 1'b1, 1'b0, od);
        do_move(4'b1000, 1'b0, 2, 1'b1, 1'b0, od);
        do_move(4'b0000, 1'b1, 1, 1'b1, 1'b0, od);
        if (UNDO_EN) check("undo1_dir", od, 2);
        do_move(4'b0000, 1'b1, 3, 1'b0, 1'b0, od);
        if (UNDO_EN) check("undo2_dir", od, 1);
        do_move(4'b0000, 1'b1, 1, 1'b1, 1'b0, od);

        // Randomized transactions against the model.
        for (int t = 0; t < 120; t++) begin
            logic [3:0] d;
            logic       u;
            int         lat;
            logic       chg;
            bit         sp;
            game_status = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            if ($urandom_range(0, 19) == 0) clear_game();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: d = 4'b0;
                4, 5, 6:    d = 4'b0001 << $urandom_range(0, 3);
                default:    d = 4'($urandom_range(1, 15));
            endcase
            u   = (d == 4'b0) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 6);
            chg = ($urandom_range(0, 3) != 0);
            sp  = 1'($urandom_range(0, 1));
            do_move(d, u, lat, chg, sp, od);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
